// File: rtl/laser_pkg.sv
// laser_pkg: state encoding and width helpers shared by the laser_cover files.
package laser_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SCAN1, SCAN2, REF1, REF2, FIN} state_t;
  function automatic int sq_w(input int cw);
    return 2 * cw;
  endfunction
  function automatic int sum_w(input int cw);
    return 2 * cw + 1;
  endfunction
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/laser_incircle.sv
// laser_incircle: asserts cov_o when a point lies within squared radius R2 of a centre.
module laser_incircle import laser_pkg::*; #(
  parameter int CW = 4,
  parameter int R2 = 16
) (
  input  logic [CW-1:0] cx_i,
  input  logic [CW-1:0] cy_i,
  input  logic [CW-1:0] px_i,
  input  logic [CW-1:0] py_i,
  output logic          cov_o
);
  localparam int SQW = sq_w(CW);
  localparam int SMW = sum_w(CW);
  localparam logic [31:0] R2U = 32'(R2);
  logic [CW-1:0] dx, dy;
  logic [SQW-1:0] dx2, dy2;
  logic [SMW-1:0] sum;
  always_comb begin
    dx    = cx_i >= px_i ? cx_i - px_i : px_i - cx_i;
    dy    = cy_i >= py_i ? cy_i - py_i : py_i - cy_i;
    dx2   = SQW'(dx) * SQW'(dx);
    dy2   = SQW'(dy) * SQW'(dy);
    sum   = SMW'(dx2) + SMW'(dy2);
    cov_o = 32'(sum) <= R2U;
  end
endmodule

// File: rtl/laser_cover.sv
// laser_cover: places two laser circles by exhaustive raster scans plus alternating refinement.
// Defining LASER_COVER_SCORE_EN adds the SCORE output (final union count).
module laser_cover import laser_pkg::*; #(
  parameter int CW       = 4,
  parameter int NPTS     = 40,
  parameter int R2       = 16,
  parameter int MAX_PASS = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IN_VALID,
  input  logic [CW-1:0]             X,
  input  logic [CW-1:0]             Y,
  output logic                      IN_READY,
  output logic [CW-1:0]             C1X,
  output logic [CW-1:0]             C1Y,
  output logic [CW-1:0]             C2X,
  output logic [CW-1:0]             C2Y,
`ifdef LASER_COVER_SCORE_EN
  output logic [$clog2(NPTS+1)-1:0] SCORE,
`endif
  output logic                      DONE
);
  localparam int KW = cnt_w(NPTS);
  localparam int AW = $clog2(NPTS);
  localparam int PW = $clog2(MAX_PASS + 1);
  localparam logic [KW-1:0] NP = KW'(NPTS);
  localparam logic [PW-1:0] MP = PW'(MAX_PASS);
  state_t state_q, state_d;
  logic [CW-1:0] px_q [NPTS];
  logic [CW-1:0] py_q [NPTS];
  logic [KW-1:0] idx_q, idx_d, cnt_q, cnt_d, best_q, best_d, union_q, union_d, nb;
  logic [CW-1:0] cx_q, cx_d, cy_q, cy_d, bx_q, bx_d, by_q, by_d, nbx, nby;
  logic [CW-1:0] c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
  logic [PW-1:0] pass_q, pass_d;
  logic [AW-1:0] pidx;
  logic acc, cov_cur, cov_fix, hit, better, fix2;
  assign pidx     = idx_q[AW-1:0];
  assign fix2     = state_q == REF1;
  assign IN_READY = state_q == IDLE || state_q == LOAD;
  assign DONE     = state_q == FIN;
  assign {C1X, C1Y, C2X, C2Y} = {c1x_q, c1y_q, c2x_q, c2y_q};
`ifdef LASER_COVER_SCORE_EN
  assign SCORE = union_q;
`endif
  laser_incircle #(.CW(CW), .R2(R2)) u_cur (
    .cx_i(cx_q), .cy_i(cy_q), .px_i(px_q[pidx]), .py_i(py_q[pidx]), .cov_o(cov_cur)
  );
  // The fixed circle is C2 while C1 is being refined, C1 otherwise.
  laser_incircle #(.CW(CW), .R2(R2)) u_fix (
    .cx_i(fix2 ? c2x_q : c1x_q), .cy_i(fix2 ? c2y_q : c1y_q),
    .px_i(px_q[pidx]), .py_i(py_q[pidx]), .cov_o(cov_fix)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    best_d  = best_q;
    union_d = union_q;
    pass_d  = pass_q;
    {cx_d, cy_d, bx_d, by_d}     = {cx_q, cy_q, bx_q, by_q};
    {c1x_d, c1y_d, c2x_d, c2y_d} = {c1x_q, c1y_q, c2x_q, c2y_q};
    acc    = IN_VALID && IN_READY;
    hit    = state_q == SCAN1 ? cov_cur : cov_cur | cov_fix;
    better = cnt_q > best_q;
    nb     = better ? cnt_q : best_q;
    nbx    = better ? cx_q : bx_q;
    nby    = better ? cy_q : by_q;
    case (state_q)
      IDLE: if (acc) begin
        state_d = LOAD;
        idx_d   = KW'(1);
        pass_d  = '0;
      end
      LOAD: if (acc) begin
        idx_d   = idx_q == NP - KW'(1) ? '0 : idx_q + KW'(1);
        state_d = idx_q == NP - KW'(1) ? SCAN1 : LOAD;
      end
      FIN: state_d = IDLE;
      default: if (idx_q != NP) begin
        idx_d = idx_q + KW'(1);
        cnt_d = cnt_q + KW'(hit);
      end else begin
        // Score complete: keep strictly better candidate, step centre in raster order.
        idx_d = '0;
        cnt_d = '0;
        {cy_d, cx_d} = {cy_q, cx_q} + (2*CW)'(1);
        {best_d, bx_d, by_d} = {nb, nbx, nby};
        if (&{cy_q, cx_q}) begin
          {best_d, bx_d, by_d} = '0;
          if (state_q inside {SCAN1, REF1}) {c1x_d, c1y_d} = {nbx, nby};
          else {c2x_d, c2y_d} = {nbx, nby};
          if (state_q inside {SCAN2, REF2}) union_d = nb;
          if (state_q == REF2) pass_d = pass_q + PW'(1);
          state_d = state_q == SCAN1 ? SCAN2 :
                    state_q == SCAN2 ? REF1 :
                    state_q == REF1 ? REF2 :
                    nb > union_q && pass_q + PW'(1) < MP ? REF1 : FIN;
        end
      end
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      {idx_q, cnt_q, best_q, union_q, pass_q} <= '0;
      {cx_q, cy_q, bx_q, by_q} <= '0;
      {c1x_q, c1y_q, c2x_q, c2y_q} <= '0;
    end else begin
      state_q <= state_d;
      {idx_q, cnt_q, best_q, union_q, pass_q} <= {idx_d, cnt_d, best_d, union_d, pass_d};
      {cx_q, cy_q, bx_q, by_q} <= {cx_d, cy_d, bx_d, by_d};
      {c1x_q, c1y_q, c2x_q, c2y_q} <= {c1x_d, c1y_d, c2x_d, c2y_d};
    end
  end
  always_ff @(posedge CLK) begin
    if (acc) begin
      px_q[pidx] <= X;
      py_q[pidx] <= Y;
    end
  end
endmodule

// File: tb/tb_laser_cover.sv
// tb_laser_cover: scoreboard bench for laser_cover (default, small and CW=3 builds run in parallel).
module tb_laser_cover;
  typedef struct {
    logic [31:0] c1x, c1y, c2x, c2y, score;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  exp_t q_a[$], q_s[$], q_m[$];
  logic rst_a, v_a, rdy_a, done_a;
  logic [3:0] x_a, y_a, c1x_a, c1y_a, c2x_a, c2y_a;
  logic [5:0] score_a;
  logic rst_s, v_s, rdy_s, done_s;
  logic [3:0] x_s, y_s, c1x_s, c1y_s, c2x_s, c2y_s;
  logic [2:0] score_s;
  logic rst_m, v_m, rdy_m, done_m;
  logic [2:0] x_m, y_m, c1x_m, c1y_m, c2x_m, c2y_m;
  logic [3:0] score_m;
  logic [3:0] ic_cx, ic_cy, ic_px, ic_py;
  logic ic_cov;
  int mpx[2][8] = '{'{0, 1, 0, 7, 6, 7, 3, 5}, '{2, 4, 3, 6, 6, 0, 7, 3}};
  int mpy[2][8] = '{'{0, 0, 1, 7, 7, 6, 3, 2}, '{5, 5, 7, 1, 3, 7, 0, 5}};
  int ic_tab[8][5] = '{'{4, 4, 8, 4, 1}, '{4, 4, 8, 5, 0}, '{0, 0, 15, 6, 0}, '{15, 15, 0, 0, 0},
                       '{5, 9, 5, 5, 1}, '{3, 3, 0, 0, 0}, '{0, 0, 2, 2, 1}, '{9, 2, 9, 6, 1}};
`ifndef LASER_COVER_SCORE_EN
  assign score_a = '0;
  assign score_s = '0;
  assign score_m = '0;
`endif

  laser_cover u_a (
    .CLK(clk), .RST(rst_a), .IN_VALID(v_a), .X(x_a), .Y(y_a), .IN_READY(rdy_a),
    .C1X(c1x_a), .C1Y(c1y_a), .C2X(c2x_a), .C2Y(c2y_a),
`ifdef LASER_COVER_SCORE_EN
    .SCORE(score_a),
`endif
    .DONE(done_a)
  );
  laser_cover #(.NPTS(4)) u_s (
    .CLK(clk), .RST(rst_s), .IN_VALID(v_s), .X(x_s), .Y(y_s), .IN_READY(rdy_s),
    .C1X(c1x_s), .C1Y(c1y_s), .C2X(c2x_s), .C2Y(c2y_s),
`ifdef LASER_COVER_SCORE_EN
    .SCORE(score_s),
`endif
    .DONE(done_s)
  );
  laser_cover #(.CW(3), .NPTS(8), .R2(4)) u_m (
    .CLK(clk), .RST(rst_m), .IN_VALID(v_m), .X(x_m), .Y(y_m), .IN_READY(rdy_m),
    .C1X(c1x_m), .C1Y(c1y_m), .C2X(c2x_m), .C2Y(c2y_m),
`ifdef LASER_COVER_SCORE_EN
    .SCORE(score_m),
`endif
    .DONE(done_m)
  );
  laser_incircle #(.CW(4), .R2(16)) u_ic (
    .cx_i(ic_cx), .cy_i(ic_cy), .px_i(ic_px), .py_i(ic_py), .cov_o(ic_cov)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_frame(input string tag, input exp_t e, input logic [31:0] c1x, c1y, c2x, c2y, sc);
    chk({tag, "_c1x"}, c1x, e.c1x);
    chk({tag, "_c1y"}, c1y, e.c1y);
    chk({tag, "_c2x"}, c2x, e.c2x);
    chk({tag, "_c2y"}, c2y, e.c2y);
`ifdef LASER_COVER_SCORE_EN
    chk({tag, "_score"}, sc, e.score);
`endif
  endtask

  task automatic unexpected(input string tag);
    n_tests++;
    n_fail++;
    $display("FAIL %s_done: got DONE, expected no pending frame", tag);
  endtask

  always @(negedge clk) if (done_a === 1'b1) begin
    if (q_a.size() == 0) unexpected("A");
    else check_frame("A", q_a.pop_front(), c1x_a, c1y_a, c2x_a, c2y_a, 32'(score_a));
  end
  always @(negedge clk) if (done_s === 1'b1) begin
    if (q_s.size() == 0) unexpected("S");
    else check_frame("S", q_s.pop_front(), c1x_s, c1y_s, c2x_s, c2y_s, 32'(score_s));
  end
  always @(negedge clk) if (done_m === 1'b1) begin
    if (q_m.size() == 0) unexpected("M");
    else check_frame("M", q_m.pop_front(), c1x_m, c1y_m, c2x_m, c2y_m, 32'(score_m));
  end

  function automatic bit m_cov(input int cx, cy, px, py);
    return (cx - px) * (cx - px) + (cy - py) * (cy - py) <= 4;
  endfunction

  function automatic void m_scan(input int f, input bit uni, input int fx, fy, output int bx, by, best);
    bx = 0;
    by = 0;
    best = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        int s;
        s = 0;
        for (int i = 0; i < 8; i++)
          if (m_cov(x, y, mpx[f][i], mpy[f][i]) || (uni && m_cov(fx, fy, mpx[f][i], mpy[f][i]))) s++;
        if (s > best) begin
          best = s;
          bx = x;
          by = y;
        end
      end
  endfunction

  function automatic exp_t m_model(input int f);
    int c1x, c1y, c2x, c2y, u, nu, s;
    exp_t e;
    m_scan(f, 1'b0, 0, 0, c1x, c1y, s);
    m_scan(f, 1'b1, c1x, c1y, c2x, c2y, u);
    for (int p = 0; p < 8; p++) begin
      m_scan(f, 1'b1, c2x, c2y, c1x, c1y, s);
      m_scan(f, 1'b1, c1x, c1y, c2x, c2y, nu);
      if (nu <= u) break;
      u = nu;
    end
    e = '{c1x, c1y, c2x, c2y, u};
    return e;
  endfunction

  task automatic run_a();
    int acc = 0;
    int k = 0;
    int t = 0;
    q_a.push_back('{7, 3, 0, 0, 40});
    while (acc < 40 && k < 200) begin
      @(negedge clk);
      v_a = k[0] == 1'b0;
      x_a = 4'd7;
      y_a = 4'd7;
      if (v_a && rdy_a) acc++;
      k++;
    end
    chk("A_accepts", acc, 40);
    @(negedge clk);
    chk("A_ready_drop", rdy_a, 0);
    {v_a, x_a, y_a} = {1'b1, 4'd0, 4'd0};
    repeat (300) @(negedge clk);
    chk("A_ready_scan", rdy_a, 0);
    v_a = 1'b0;
    while (done_a !== 1'b1 && t < 45000) begin
      @(negedge clk);
      t++;
    end
    chk("A_done_seen", done_a, 1);
    @(negedge clk);
    chk("A_done_pulse", {done_a, rdy_a}, 2'b01);
    repeat (4) @(negedge clk);
    chk("A_hold", {c1x_a, c1y_a, c2x_a, c2y_a}, 16'h7300);
  endtask

  task automatic load_s();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v_s = 1'b1;
      x_s = i < 2 ? 4'd2 : 4'd12;
      y_s = i < 2 ? 4'd2 : 4'd12;
    end
    @(negedge clk);
    v_s = 1'b0;
  endtask

  task automatic wait_s(input string nm);
    int t = 0;
    while (done_s !== 1'b1 && t < 6000) begin
      @(negedge clk);
      t++;
    end
    chk(nm, done_s, 1);
    @(negedge clk);
    chk({nm, "_pulse"}, {done_s, rdy_s}, 2'b01);
  endtask

  task automatic run_s();
    q_s.push_back('{0, 0, 12, 8, 4});
    load_s();
    wait_s("S_done_1");
    load_s();
    repeat (2600) @(negedge clk);
    chk("S_pre_rst_c2", {c2x_s, c2y_s}, 8'hC8);
    rst_s = 1'b1;
    @(negedge clk);
    chk("S_rst_outs", {c1x_s, c1y_s, c2x_s, c2y_s, done_s, rdy_s}, {16'h0, 2'b01});
    rst_s = 1'b0;
    @(negedge clk);
    chk("S_rst_idle", rdy_s, 1);
    q_s.push_back('{0, 0, 12, 8, 4});
    load_s();
    wait_s("S_done_2");
  endtask

  task automatic run_m();
    for (int f = 0; f < 2; f++) begin
      int t = 0;
      q_m.push_back(m_model(f));
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        v_m = 1'b1;
        x_m = 3'(mpx[f][i]);
        y_m = 3'(mpy[f][i]);
      end
      @(negedge clk);
      v_m = 1'b0;
      while (done_m !== 1'b1 && t < 18 * 64 * 9 + 20) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("M_done_%0d", f), done_m, 1);
      @(negedge clk);
      chk($sformatf("M_pulse_%0d", f), {done_m, rdy_m}, 2'b01);
    end
  endtask

  initial begin
    {rst_a, rst_s, rst_m} = 3'b111;
    {v_a, v_s, v_m} = 3'b000;
    {x_a, y_a, x_s, y_s} = '0;
    {x_m, y_m} = '0;
    {ic_cx, ic_cy, ic_px, ic_py} = '0;
    repeat (3) @(negedge clk);
    chk("A_in_rst", {c1x_a, c1y_a, c2x_a, c2y_a, done_a}, 0);
    {rst_a, rst_s, rst_m} = 3'b000;
    @(negedge clk);
    chk("A_rst_outs", {c1x_a, c1y_a, c2x_a, c2y_a, done_a, rdy_a}, {16'h0, 2'b01});
    chk("S_rst_outs0", {c1x_s, c1y_s, c2x_s, c2y_s, done_s, rdy_s}, {16'h0, 2'b01});
    chk("M_rst_outs0", {c1x_m, c1y_m, c2x_m, c2y_m, done_m, rdy_m}, {12'h0, 2'b01});
`ifdef LASER_COVER_SCORE_EN
    chk("A_rst_score", score_a, 0);
`endif
    for (int i = 0; i < 8; i++) begin
      {ic_cx, ic_cy, ic_px, ic_py} = {4'(ic_tab[i][0]), 4'(ic_tab[i][1]), 4'(ic_tab[i][2]), 4'(ic_tab[i][3])};
      #1;
      chk($sformatf("IC_%0d", i), ic_cov, ic_tab[i][4]);
    end
    fork
      run_a();
      run_s();
      run_m();
    join
    chk("A_queue_left", q_a.size(), 0);
    chk("S_queue_left", q_s.size(), 0);
    chk("M_queue_left", q_m.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
